// File: rtl/dial_pkg.sv
// Shared constants and helpers for the dial input accumulator.
package dial_pkg;

    // Spinner gain encoding: the value is the left-shift applied to each delta.
    localparam logic [1:0] SENS_X1 = 2'd0;
    localparam logic [1:0] SENS_X2 = 2'd1;
    localparam logic [1:0] SENS_X4 = 2'd2;
    localparam logic [1:0] SENS_X8 = 2'd3;

    // Default tuning values.
    localparam int DEADZONE_DEF = 16;
    localparam int BTN_DIV_DEF  = 4;

    // Adds b to a and clamps the result symmetrically to +/-(2^(width-1)-1).
    // The clamped flag reports whether the limit was applied.
    function automatic logic signed [31:0] sat_add(
        input  logic signed [31:0] a,
        input  logic signed [31:0] b,
        input  int                 width,
        output logic               clamped
    );
        logic signed [31:0] lim;
        logic signed [31:0] s;
        lim     = (32'sd1 <<< (width - 1)) - 32'sd1;
        s       = a + b;
        clamped = 1'b0;
        if (s > lim) begin
            s       = lim;
            clamped = 1'b1;
        end else if (s < -lim) begin
            s       = -lim;
            clamped = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/dial_rate_gen.sv
// Rate tick prescaler plus the analog-stick phase accumulator and the
// button repeat counter. Both motion sources only advance on a tick.
module dial_rate_gen
    import dial_pkg::*;
#(
    parameter int STEP_DIV = 1000,
    parameter int DEADZONE = DEADZONE_DEF,
    parameter int BTN_DIV  = BTN_DIV_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              enable,
    input  logic signed [7:0] analog_x,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic              tick,
    output logic signed [1:0] analog_step,
    output logic signed [1:0] btn_step
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int BW = (BTN_DIV > 1) ? $clog2(BTN_DIV) : 1;

    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    phase_reg, phase_next;
    logic [BW-1:0] btn_cnt_reg, btn_cnt_next;
    logic [6:0]    mag;
    logic [8:0]    phase_sum;

    // Stick magnitude; -128 folds onto 127 so it fits in 7 bits.
    always_comb begin
        mag = analog_x[6:0];
        if (analog_x == -8'sd128) begin
            mag = 7'd127;
        end else if (analog_x[7]) begin
            mag = 7'(-analog_x);
        end
    end

    // Next-state for prescaler, phase and button counter; contributions are
    // combinational on the tick cycle so they join the same pending update.
    always_comb begin
        presc_next   = presc_reg;
        phase_next   = phase_reg;
        btn_cnt_next = btn_cnt_reg;
        analog_step  = 2'sb00;
        btn_step     = 2'sb00;
        tick         = enable && (presc_reg == PW'(STEP_DIV - 1));
        phase_sum    = {1'b0, phase_reg} + {2'b00, mag - 7'(DEADZONE)};
        if (!enable) begin
            presc_next   = '0;
            phase_next   = '0;
            btn_cnt_next = '0;
        end else begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                if (mag > 7'(DEADZONE)) begin
                    phase_next = phase_sum[7:0];
                    if (phase_sum[8]) begin
                        analog_step = analog_x[7] ? 2'sb11 : 2'sb01;
                    end
                end else begin
                    phase_next = '0;
                end
                if (btn_left ^ btn_right) begin
                    if (btn_cnt_reg == BW'(BTN_DIV - 1)) begin
                        btn_cnt_next = '0;
                        btn_step     = btn_right ? 2'sb01 : 2'sb11;
                    end else begin
                        btn_cnt_next = btn_cnt_reg + 1'b1;
                    end
                end else begin
                    btn_cnt_next = '0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            phase_reg   <= '0;
            btn_cnt_reg <= '0;
        end else begin
            presc_reg   <= presc_next;
            phase_reg   <= phase_next;
            btn_cnt_reg <= btn_cnt_next;
        end
    end

endmodule

// File: rtl/dial_input_accum.sv
// Turns spinner deltas, stick X and left/right buttons into an 8-bit dial
// position that moves at most one count per rate tick.
module dial_input_accum
    import dial_pkg::*;
#(
    parameter int STEP_DIV = 1000,
    parameter int PEND_W   = 10,
    parameter int DEADZONE = DEADZONE_DEF,
    parameter int BTN_DIV  = BTN_DIV_DEF
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [8:0]               spinner,
    input  logic signed [7:0]        analog_x,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic [1:0]               sens,
    input  logic                     clear_ovf,
    output logic [7:0]               dial,
    output logic signed [PEND_W-1:0] pending,
    output logic                     ovf
);

    // Delta is formed at PEND_W+3 bits so an x8 gain never wraps before clamping.
    localparam int DW = PEND_W + 3;

    logic                     armed_reg;
    logic                     prev_toggle_reg;
    logic signed [DW-1:0]     delta_reg, delta_next;
    logic signed [DW-1:0]     spin_ext;
    logic signed [PEND_W-1:0] pending_reg, pending_next;
    logic [7:0]               dial_reg, dial_next;
    logic                     ovf_reg, ovf_next;
    logic                     spin_event;
    logic                     tick;
    logic signed [1:0]        analog_step;
    logic signed [1:0]        btn_step;
    logic signed [1:0]        step_dir;
    logic signed [31:0]       incr;
    logic                     clamped;

    dial_rate_gen #(
        .STEP_DIV (STEP_DIV),
        .DEADZONE (DEADZONE),
        .BTN_DIV  (BTN_DIV)
    ) u_rate (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .enable      (enable),
        .analog_x    (analog_x),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .tick        (tick),
        .analog_step (analog_step),
        .btn_step    (btn_step)
    );

    // Toggle detection and gain; the scaled delta is registered, giving one
    // cycle of latency before it reaches the pending accumulator.
    always_comb begin
        spin_event = armed_reg && enable && (spinner[8] != prev_toggle_reg);
        spin_ext   = DW'(signed'(spinner[7:0]));
        delta_next = '0;
        if (spin_event) begin
            unique case (sens)
                SENS_X1: delta_next = spin_ext;
                SENS_X2: delta_next = spin_ext <<< 1;
                SENS_X4: delta_next = spin_ext <<< 2;
                SENS_X8: delta_next = spin_ext <<< 3;
            endcase
        end
    end

    // Step direction, pending sum with saturation, sticky overflow and dial.
    always_comb begin
        step_dir = 2'sb00;
        clamped  = 1'b0;
        if (tick) begin
            if (pending_reg[PEND_W-1]) begin
                step_dir = 2'sb11;
            end else if (pending_reg != '0) begin
                step_dir = 2'sb01;
            end
        end
        incr = 32'(delta_reg) + 32'(analog_step) + 32'(btn_step) - 32'(step_dir);
        pending_next = PEND_W'(sat_add(32'(pending_reg), incr, PEND_W, clamped));
        if (!enable) begin
            pending_next = '0;
        end
        if (enable && clamped) begin
            ovf_next = 1'b1;
        end else if (clear_ovf) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
        dial_next = dial_reg + 8'(step_dir);
    end

    // State registers; prev_toggle follows the spinner even while disabled.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg       <= 1'b0;
            prev_toggle_reg <= 1'b0;
            delta_reg       <= '0;
            pending_reg     <= '0;
            dial_reg        <= '0;
            ovf_reg         <= 1'b0;
        end else begin
            armed_reg       <= 1'b1;
            prev_toggle_reg <= spinner[8];
            delta_reg       <= delta_next;
            pending_reg     <= pending_next;
            dial_reg        <= dial_next;
            ovf_reg         <= ovf_next;
        end
    end

    assign dial    = dial_reg;
    assign pending = pending_reg;
    assign ovf     = ovf_reg;

endmodule

// File: doc/dial_input_accum.md
Name: dial_input_accum

Overview:
Converts MiSTer spinner deltas, left-stick X and digital left/right buttons into the 8-bit free-running dial position presented to the board's spinner input port (IPA1J2) for Mad Planets.
Motion is queued in a signed pending accumulator and released one count per rate tick, so the game CPU sees encoder-like single steps rather than jumps.
Sits between hps_io joystick/spinner outputs and the input mux feeding mylstar_board.

Parameters:
STEP_DIV, 1000, clk_sys cycles per rate tick (one dial count maximum per tick); minimum 2.
PEND_W, 10, width of the signed pending accumulator.
DEADZONE, 16, analog magnitude at or below which the stick is ignored.
BTN_DIV, 4, rate ticks per button-driven step.

Ports:
clk_sys  input  1  core clock; all state on posedge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  high when the loaded game uses a dial; low freezes the dial and flushes state.
spinner  input  9  [7:0] signed delta, [8] toggles once per new report.
analog_x  input  8  signed stick X, -128..127.
btn_left  input  1  digital decrement request.
btn_right  input  1  digital increment request.
sens  input  2  spinner gain: delta shifted left by sens (x1/x2/x4/x8).
clear_ovf  input  1  synchronous clear of ovf.
dial  output  8  dial position, wraps mod 256.
pending  output  PEND_W  signed queued motion (debug).
ovf  output  1  sticky: pending saturated.

Behaviour:
- Reset (async assert, sync release): dial=0, pending=0, ovf=0, prescaler=0, analog phase=0, button counter=0, armed=0.
- Arming: the first clk_sys after release loads prev_toggle=spinner[8], sets armed=1 and generates no event.
- Spinner event: armed and spinner[8]!=prev_toggle. Delta = sign-extended spinner[7:0] << sens, computed at PEND_W+3 bits. Added to pending the cycle after the toggle is seen (1-cycle latency). prev_toggle updates every cycle.
- Rate tick: prescaler counts 0..STEP_DIV-1; tick=1 for one cycle when the count is STEP_DIV-1, then the count wraps to 0.
- Analog path, on tick only:
  - mag = |analog_x|; -128 is treated as magnitude 127.
  - If mag>DEADZONE, 8-bit phase += (mag-DEADZONE). The carry-out contributes sign(analog_x)*1.
  - If mag<=DEADZONE, phase is cleared to 0.
- Button path, on tick only:
  - Exactly one button held: the counter increments; on reaching BTN_DIV-1 it contributes +1 (right) or -1 (left) and resets to 0.
  - Both buttons or neither held: counter=0, no contribution.
- Step, on tick only: if pending>0, dial+=1 and pending-=1; if pending<0, dial-=1 and pending+=1; if pending=0, no step. Dial wraps 255->0 and 0->255.
- Per-cycle update: pending_next = pending + spinner_delta + analog_contrib + button_contrib - step_dir. All terms are summed in one cycle; simultaneous events are never lost or serialised.
- Saturation: pending_next is clamped to ±(2^(PEND_W-1)-1). Any clamp sets ovf. ovf clears only on clear_ovf; a set and a clear in the same cycle resolves to set.
- enable=0:
  - dial holds; pending, phase, prescaler and button counter clear to 0.
  - prev_toggle keeps tracking, so a stale toggle produces no event when enable rises.
- Worst-case dial slew is 1 count per STEP_DIV cycles, independent of input rate.

Decomposition:
- Package dial_pkg: sens encoding constants, a saturating-add function parameterised on width, and DEADZONE/BTN_DIV default localparams.
- Sub-module dial_rate_gen: prescaler, analog phase accumulator and button counter. Outputs tick and a signed 2-bit contribution (-1/0/+1 each for analog and button).
- Top level holds toggle detection, the pending accumulator with saturation, and the dial register.

Test Plan:
1. Reset with spinner[8]=1 held, then release -> no event, pending=0, dial=0.
2. STEP_DIV=4, sens=0, a single toggle with delta=+3 -> pending=3 one cycle later. Dial reaches 1, 2, 3 on three consecutive ticks, 4 cycles apart; pending ends at 0.
3. dial=1, delta=-5 -> dial goes 0, 255, 254, 253, 252 (wrap), then holds.
4. PEND_W=6, sens=3, two toggles of delta=+8 -> pending clamps at 31 and ovf=1. clear_ovf pulsed -> ovf=0 while pending drains.
5. analog_x=+80, DEADZONE=16 -> 64 is added per tick, so the dial advances +1 every 4 ticks. analog_x=-128 -> -1 on ticks where the phase carries from adding 111. analog_x=+10 -> no motion and phase=0.
6. btn_right held with BTN_DIV=4 -> +1 every 4th tick; both buttons held -> no motion. Drop enable mid-drain with pending=7 -> pending=0 next cycle and dial frozen.
